// File: rtl/clock_gen_pkg.sv
// Shared constants for the multi-rate clock generator: board frequency,
// common divisors and the channel-select width helper.
package clock_gen_pkg;

  localparam int CLK_HZ        = 100_000_000;
  localparam int DIV_1HZ_TICK  = 100_000_000;
  localparam int DIV_1HZ_CLK   = 50_000_000;
  localparam int DIV_4HZ_CLK   = 12_500_000;
  localparam int DIV_1KHZ_TICK = 100_000;
  localparam int DEF_CNT_W     = 27;

  // Width of a channel index; a single channel still gets a 1-bit select.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active and deferred divisors, and the
// registered tick / toggled clock outputs.
module clk_div_channel
  import clock_gen_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int DIV_RESET = DIV_4HZ_CLK
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             i_run,
  input  logic             i_wr_now,
  input  logic             i_wr_def,
  input  logic [CNT_W-1:0] i_wr_div,
  output logic             o_tick,
  output logic             o_clk_out,
  output logic             o_pending
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_div_active;
  logic [CNT_W-1:0] r_div_next;
  logic             r_pending;
  logic             r_tick;
  logic             r_clk_out;
  logic             w_wrap;

  // Compare against div-1 so a maximal divisor never needs an extra bit.
  assign w_wrap = i_run && (r_count == r_div_active - CNT_W'(1));

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_count      <= '0;
      r_div_active <= CNT_W'(DIV_RESET);
      r_div_next   <= CNT_W'(DIV_RESET);
      r_pending    <= 1'b0;
      r_tick       <= 1'b0;
      r_clk_out    <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      // NOTE: the immediate write is tested first so it overrides a coincident wrap.
      if (i_wr_now) begin
        r_div_active <= i_wr_div;
        r_count      <= '0;
        r_pending    <= 1'b0;
      end else if (w_wrap) begin
        r_count   <= '0;
        r_tick    <= 1'b1;
        r_clk_out <= ~r_clk_out;
        if (i_wr_def) begin
          r_div_active <= i_wr_div;
          r_pending    <= 1'b0;
        end else if (r_pending) begin
          r_div_active <= r_div_next;
          r_pending    <= 1'b0;
        end
      end else begin
        if (i_run) r_count <= r_count + CNT_W'(1);
        if (i_wr_def) begin
          r_div_next <= i_wr_div;
          r_pending  <= 1'b1;
        end
      end
    end
  end

  assign o_tick    = r_tick;
  assign o_clk_out = r_clk_out;
  assign o_pending = r_pending;

endmodule

// File: rtl/multi_rate_clock_gen.sv
// NUM_CH independent clock dividers with runtime divisor writes; the top
// decodes the configuration port and flags illegal writes.
module multi_rate_clock_gen
  import clock_gen_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int DIV_RESET = DIV_4HZ_CLK
) (
  input  logic                       clk_in,
  input  logic                       rst,
  input  logic                       en,
  input  logic [NUM_CH-1:0]          ch_en,
  input  logic                       cfg_we,
  input  logic [sel_w(NUM_CH)-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]           cfg_div,
  input  logic                       cfg_now,
  output logic [NUM_CH-1:0]          tick,
  output logic [NUM_CH-1:0]          clk_out,
  output logic [NUM_CH-1:0]          div_pending,
  output logic                       cfg_err
);

  localparam int CH_W = sel_w(NUM_CH);
  localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

  logic w_legal;
  logic r_cfg_err;

  assign w_legal = (cfg_div != '0) && ({1'b0, cfg_ch} < NUM_CH_L);

  always_ff @(posedge clk_in) begin
    if (rst) r_cfg_err <= 1'b0;
    else     r_cfg_err <= cfg_we && !w_legal;
  end

  assign cfg_err = r_cfg_err;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic w_sel;
    assign w_sel = cfg_we && w_legal && (cfg_ch == CH_W'(i));

    clk_div_channel #(
      .CNT_W     (CNT_W),
      .DIV_RESET (DIV_RESET)
    ) u_ch (
      .clk_in    (clk_in),
      .rst       (rst),
      .i_run     (en && ch_en[i]),
      .i_wr_now  (w_sel && cfg_now),
      .i_wr_def  (w_sel && !cfg_now),
      .i_wr_div  (cfg_div),
      .o_tick    (tick[i]),
      .o_clk_out (clk_out[i]),
      .o_pending (div_pending[i])
    );
  end

endmodule

// File: tb/tb_multi_rate_clock_gen.sv
// Directed bench: each phase resets the block, queues the outputs expected at
// absolute edge numbers, then drives the stimulus; a negedge monitor pops and compares.
module tb_multi_rate_clock_gen;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 27;
  localparam int K_TICK = 0;
  localparam int K_CLK  = 1;
  localparam int K_PEND = 2;
  localparam int K_ERR  = 3;

  typedef struct {
    int          cyc;
    int          kind;
    logic [2:0]  val;
    string       tag;
  } exp_t;

  logic              clk_in;
  logic              rst;
  logic              en;
  logic [NUM_CH-1:0] ch_en;
  logic              cfg_we;
  logic [1:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic              cfg_now;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] div_pending;
  logic              cfg_err;

  exp_t  sb[$];
  int    cyc = 0;
  int    base = 0;
  int    n_checks = 0;
  int    n_errors = 0;
  string ph = "";

  multi_rate_clock_gen #(
    .NUM_CH    (NUM_CH),
    .CNT_W     (CNT_W),
    .DIV_RESET (4)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .en          (en),
    .ch_en       (ch_en),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .cfg_now     (cfg_now),
    .tick        (tick),
    .clk_out     (clk_out),
    .div_pending (div_pending),
    .cfg_err     (cfg_err)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    logic [2:0] obs;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        case (sb[i].kind)
          K_TICK:  obs = tick;
          K_CLK:   obs = clk_out;
          K_PEND:  obs = div_pending;
          default: obs = {2'b00, cfg_err};
        endcase
        n_checks++;
        assert (obs === sb[i].val) else begin
          n_errors++;
          $error("FAIL %s edge=%0d observed=%b expected=%b", sb[i].tag, cyc, obs, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic push(input int off, input int kind, input logic [2:0] v);
    exp_t e;
    string kn;
    case (kind)
      K_TICK:  kn = "tick";
      K_CLK:   kn = "clk_out";
      K_PEND:  kn = "pending";
      default: kn = "cfg_err";
    endcase
    e.cyc  = base + off;
    e.kind = kind;
    e.val  = v;
    e.tag  = $sformatf("%s_%s+%0d", ph, kn, off);
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic run_to(input int e);
    while (cyc < e) step(1);
  endtask

  // Drive a write so that it is sampled at edge base+off.
  task automatic wr_at(input int off, input logic [1:0] ch, input int div, input logic now);
    run_to(base + off - 1);
    cfg_we  = 1'b1;
    cfg_ch  = ch;
    cfg_div = CNT_W'(div);
    cfg_now = now;
    step(1);
    cfg_we  = 1'b0;
  endtask

  // base becomes the last edge that samples rst high.
  task automatic do_reset(input string name);
    ph     = name;
    rst    = 1'b1;
    en     = 1'b1;
    ch_en  = '1;
    cfg_we = 1'b0;
    step(2);
    base = cyc;
    push(0, K_TICK, 3'b000);
    push(0, K_CLK,  3'b000);
    push(0, K_PEND, 3'b000);
    push(0, K_ERR,  3'b000);
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    en      = 1'b1;
    ch_en   = '1;
    cfg_we  = 1'b0;
    cfg_ch  = '0;
    cfg_div = '0;
    cfg_now = 1'b0;
    step(2);

    // Plain divide-by-4 from reset.
    do_reset("rst");
    push(3,  K_TICK, 3'b000);
    push(4,  K_TICK, 3'b111);
    push(5,  K_TICK, 3'b000);
    push(8,  K_TICK, 3'b111);
    push(12, K_TICK, 3'b111);
    push(4,  K_CLK,  3'b111);
    push(7,  K_CLK,  3'b111);
    push(8,  K_CLK,  3'b000);
    push(8,  K_PEND, 3'b000);
    run_to(base + 13);

    // Deferred writes: ch1 5->3 mid-count, ch0 ->2 on its own wrap edge.
    do_reset("defer");
    push(1,  K_TICK, 3'b000);
    push(4,  K_TICK, 3'b101);
    push(5,  K_TICK, 3'b000);
    push(6,  K_TICK, 3'b010);
    push(8,  K_TICK, 3'b101);
    push(9,  K_TICK, 3'b010);
    push(10, K_TICK, 3'b001);
    push(11, K_TICK, 3'b000);
    push(12, K_TICK, 3'b111);
    push(2,  K_PEND, 3'b000);
    push(3,  K_PEND, 3'b010);
    push(5,  K_PEND, 3'b010);
    push(6,  K_PEND, 3'b000);
    push(8,  K_PEND, 3'b000);
    push(6,  K_CLK,  3'b111);
    push(9,  K_CLK,  3'b000);
    push(10, K_CLK,  3'b001);
    push(3,  K_ERR,  3'b000);
    wr_at(1, 2'd1, 5, 1'b1);
    wr_at(3, 2'd1, 3, 1'b0);
    wr_at(8, 2'd0, 2, 1'b0);
    run_to(base + 13);

    // Immediate writes: ch0 8->2 at count 5, ch2 ->3 on its terminal count.
    do_reset("now");
    push(4,  K_TICK, 3'b110);
    push(7,  K_TICK, 3'b000);
    push(8,  K_TICK, 3'b110);
    push(9,  K_TICK, 3'b001);
    push(10, K_TICK, 3'b000);
    push(11, K_TICK, 3'b001);
    push(12, K_TICK, 3'b010);
    push(13, K_TICK, 3'b001);
    push(15, K_TICK, 3'b101);
    push(7,  K_CLK,  3'b110);
    push(9,  K_CLK,  3'b001);
    push(12, K_CLK,  3'b010);
    push(15, K_CLK,  3'b110);
    wr_at(1,  2'd0, 8, 1'b1);
    wr_at(7,  2'd0, 2, 1'b1);
    wr_at(12, 2'd2, 3, 1'b1);
    run_to(base + 16);

    // Illegal writes leave every channel untouched.
    do_reset("illegal");
    push(2, K_ERR,  3'b001);
    push(3, K_ERR,  3'b001);
    push(4, K_ERR,  3'b000);
    push(5, K_ERR,  3'b001);
    push(6, K_ERR,  3'b001);
    push(7, K_ERR,  3'b000);
    push(5, K_PEND, 3'b000);
    push(7, K_PEND, 3'b000);
    push(4, K_TICK, 3'b111);
    push(7, K_TICK, 3'b000);
    push(8, K_TICK, 3'b111);
    wr_at(2, 2'd1, 0, 1'b1);
    wr_at(3, 2'd3, 2, 1'b1);
    wr_at(5, 2'd0, 0, 1'b0);
    wr_at(6, 2'd3, 1, 1'b0);
    run_to(base + 9);

    // Freeze ch2 alone, then all channels with a deferred write held pending.
    do_reset("freeze");
    push(4,  K_TICK, 3'b011);
    push(5,  K_TICK, 3'b000);
    push(7,  K_TICK, 3'b100);
    push(8,  K_TICK, 3'b011);
    push(11, K_TICK, 3'b100);
    push(12, K_TICK, 3'b011);
    push(16, K_TICK, 3'b000);
    push(18, K_TICK, 3'b100);
    push(19, K_TICK, 3'b011);
    push(20, K_TICK, 3'b000);
    push(21, K_TICK, 3'b001);
    push(22, K_TICK, 3'b100);
    push(17, K_CLK,  3'b011);
    push(19, K_CLK,  3'b100);
    push(14, K_PEND, 3'b001);
    push(18, K_PEND, 3'b001);
    push(19, K_PEND, 3'b000);
    run_to(base + 2);
    ch_en = 3'b011;
    run_to(base + 5);
    ch_en = 3'b111;
    run_to(base + 12);
    en = 1'b0;
    wr_at(14, 2'd0, 2, 1'b0);
    run_to(base + 15);
    en = 1'b1;
    run_to(base + 23);

    // Divide-by-1 on ch0, then reset mid-count with a coincident write.
    do_reset("div1");
    push(1,  K_TICK, 3'b000);
    push(2,  K_TICK, 3'b001);
    push(3,  K_TICK, 3'b001);
    push(4,  K_TICK, 3'b111);
    push(5,  K_TICK, 3'b001);
    push(2,  K_CLK,  3'b001);
    push(3,  K_CLK,  3'b000);
    push(4,  K_CLK,  3'b111);
    push(5,  K_CLK,  3'b110);
    push(6,  K_TICK, 3'b000);
    push(6,  K_CLK,  3'b000);
    push(6,  K_PEND, 3'b000);
    push(6,  K_ERR,  3'b000);
    push(8,  K_TICK, 3'b000);
    push(9,  K_TICK, 3'b000);
    push(10, K_TICK, 3'b111);
    wr_at(1, 2'd0, 1, 1'b1);
    run_to(base + 5);
    rst     = 1'b1;
    cfg_we  = 1'b1;
    cfg_ch  = 2'd1;
    cfg_div = CNT_W'(2);
    cfg_now = 1'b1;
    step(1);
    rst    = 1'b0;
    cfg_we = 1'b0;
    run_to(base + 12);

    n_checks++;
    assert (sb.size() == 0) else begin
      n_errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
